// File: rtl/pe_array3x3_ctrl.sv
// Sequencer for a 3x3 window engine built from three pe_array1x3 row stages.
// Accepted windows travel a registered delay line that enables each row stage and flags the finished result.
module pe_array3x3_ctrl #(
    parameter int PE_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_start,
    input  logic [CNT_W-1:0] ctrl_win_num,
    output logic             ctrl_busy,
    output logic             ctrl_done,
    input  logic             win_valid,
    output logic             win_ready,
    output logic             pe3_array0_valid,
    output logic             pe3_array1_valid,
    output logic             pe3_array2_valid,
    output logic [1:0]       pe3_row_sel,
    output logic             pe3_o_valid,
    output logic [CNT_W-1:0] out_cnt,
    output logic [1:0]       dbg_state
);

    // Bit k of the delay line is high at t+1+k for an accept at t.
    localparam int DL_LEN = 3 * PE_LAT + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   win_num_q, win_num_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [DL_LEN-1:0]  dl_q, dl_d;
    logic               accept;

    // Handshake: a window moves when win_valid and win_ready are both high
    // in the same cycle; win_ready never depends on win_valid.
    always_comb begin
        state_d   = state_q;
        win_num_d = win_num_q;
        issued_d  = issued_q;
        out_cnt_d = out_cnt_q;

        win_ready = (state_q == S_RUN) && (issued_q < win_num_q);
        accept    = win_valid && win_ready;
        dl_d      = {dl_q[DL_LEN-2:0], accept};

        if (accept) begin
            issued_d = issued_q + CNT_W'(1);
        end
        if (dl_q[3*PE_LAT] && (out_cnt_q < win_num_q)) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    win_num_d = ctrl_win_num;
                    issued_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (ctrl_win_num == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issued_q == win_num_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == win_num_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            win_num_q <= '0;
            issued_q  <= '0;
            out_cnt_q <= '0;
            dl_q      <= '0;
        end else begin
            state_q   <= state_d;
            win_num_q <= win_num_d;
            issued_q  <= issued_d;
            out_cnt_q <= out_cnt_d;
            dl_q      <= dl_d;
        end
    end

    always_comb begin
        ctrl_busy        = (state_q != S_IDLE);
        ctrl_done        = (state_q == S_DONE);
        pe3_array0_valid = dl_q[0];
        pe3_array1_valid = dl_q[PE_LAT];
        pe3_array2_valid = dl_q[2*PE_LAT];
        pe3_o_valid      = dl_q[3*PE_LAT];
        out_cnt          = out_cnt_q;
        dbg_state        = state_q;
        // The lowest active row stage owns the fetch path.
        if (dl_q[0]) begin
            pe3_row_sel = 2'd0;
        end else if (dl_q[PE_LAT]) begin
            pe3_row_sel = 2'd1;
        end else if (dl_q[2*PE_LAT]) begin
            pe3_row_sel = 2'd2;
        end else begin
            pe3_row_sel = 2'd3;
        end
    end

endmodule
